// File: rtl/game_player.sv
// Game sequencer: loads seed/mode into the game, supervises play with win/lose
// tallies and a cycle timeout, and reports the final outcome for one cycle.
//
// state | meaning
// IDLE  | waiting for start, outputs hold last game's results
// LOAD  | one cycle driving ctl_init with the latched seed and mode
// PLAY  | game running, counting events and cycles, auto mode switching
// DONE  | one-cycle done pulse, then back to IDLE
module game_player #(
    parameter int          COUNTER_SIZE = 4,
    parameter logic [15:0] TIMEOUT      = 16'd1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [COUNTER_SIZE-1:0] seed,
    input  logic [1:0]              mode,
    input  logic                    auto_mode,
    input  logic                    win,
    input  logic                    los,
    input  logic                    gameover,
    input  logic [1:0]              who,
    output logic [1:0]              ctl_control,
    output logic                    ctl_init,
    output logic [COUNTER_SIZE-1:0] ctl_value,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              result,
    output logic [7:0]              win_cnt,
    output logic [7:0]              los_cnt,
    output logic [15:0]             play_cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] tmr_cnt;
    logic        timeout_hit;

    // Down-counter loaded with TIMEOUT; terminal count 1 marks the last PLAY cycle.
    assign timeout_hit = (state == S_PLAY) && (tmr_cnt == 16'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_LOAD;
            S_LOAD: state_next = S_PLAY;
            S_PLAY: if (gameover || timeout_hit) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_control <= 2'b00;
            ctl_init    <= 1'b0;
            ctl_value   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= 2'b00;
            win_cnt     <= 8'd0;
            los_cnt     <= 8'd0;
            play_cycles <= 16'd0;
            tmr_cnt     <= 16'd0;
        end else begin
            ctl_init <= (state_next == S_LOAD);
            busy     <= (state_next == S_LOAD) || (state_next == S_PLAY);
            done     <= (state == S_PLAY) && (state_next == S_DONE);
            case (state)
                S_IDLE: begin
                    // Clear results on the way into LOAD so they read zero during LOAD.
                    if (start) begin
                        ctl_value   <= seed;
                        ctl_control <= mode;
                        result      <= 2'b00;
                        win_cnt     <= 8'd0;
                        los_cnt     <= 8'd0;
                        play_cycles <= 16'd0;
                        tmr_cnt     <= TIMEOUT;
                    end
                end
                S_PLAY: begin
                    if (win && (win_cnt != 8'hFF)) win_cnt <= win_cnt + 8'd1;
                    if (los && (los_cnt != 8'hFF)) los_cnt <= los_cnt + 8'd1;
                    if (play_cycles != 16'hFFFF) play_cycles <= play_cycles + 16'd1;
                    if (tmr_cnt != 16'd0) tmr_cnt <= tmr_cnt - 16'd1;
                    if (auto_mode) begin
                        if (win)      ctl_control <= 2'b11;
                        else if (los) ctl_control <= 2'b10;
                    end
                    if (gameover) begin
                        result <= ((who == 2'b01) || (who == 2'b10)) ? who : 2'b00;
                    end else if (timeout_hit) begin
                        result <= 2'b11;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
